// File: rtl/pio_pkg.sv
// ---------------------------------------------------------------------------
// pio_pkg : register map constants and helpers for avalon_pio_pulse_out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pio_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  localparam int STAT_BUSY = 31;

  // Bits needed to hold values 0..value-1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pio_pulse_timer.sv
// ---------------------------------------------------------------------------
// pio_pulse_timer : reloadable down-counter that times the auto-clear pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pio_pulse_timer #(
  parameter int PULSE_CYCLES = 1000,
  parameter int CNT_W        = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             expire_o,
  output logic             pulse_done_o
);

  import pio_pkg::*;

  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             w_expire;

  assign w_expire = busy_q && (cnt_q == C_ONE);

  // A load on the expiry cycle is a retrigger, so it suppresses the done strobe
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = w_expire && !load_i;
    if (load_i) begin
      cnt_d  = C_LOAD;
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - C_ONE;
      if (w_expire) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign busy_o       = busy_q;
  assign expire_o     = w_expire;
  assign pulse_done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/avalon_pio_pulse_out.sv
// ---------------------------------------------------------------------------
// avalon_pio_pulse_out : Avalon-MM output PIO with set/clear and timed pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avalon_pio_pulse_out
  import pio_pkg::*;
#(
  parameter int                DATA_W       = 1,
  parameter logic [DATA_W-1:0] RESET_VALUE  = '0,
  parameter int                PULSE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              pulse_done
);

  localparam int CNT_W = clog2(PULSE_CYCLES + 1);

  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] w_wd;
  logic              w_wr;
  logic              w_load;
  logic              w_expire;
  logic              w_busy;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_unused_wd;

  assign w_wr        = chipselect && !write_n;
  assign w_wd        = writedata[DATA_W-1:0];
  assign w_unused_wd = ^writedata;
  assign w_load      = w_wr && (address == ADDR_PULSE) && (w_wd != '0);

  pio_pulse_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (w_load),
    .cnt_o        (w_cnt),
    .busy_o       (w_busy),
    .expire_o     (w_expire),
    .pulse_done_o (pulse_done)
  );

  // Expiry clears first; a same-cycle CPU write is then layered on top
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (w_expire) begin
      data_d = data_d & ~mask_q;
      mask_d = '0;
    end
    if (w_wr) begin
      case (address)
        ADDR_DATA: data_d = w_wd;
        ADDR_SET:  data_d = data_d | w_wd;
        ADDR_CLR:  data_d = data_d & ~w_wd;
        default: begin
          if (w_wd != '0) begin
            data_d = data_d | w_wd;
            mask_d = mask_d | w_wd;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_PULSE) begin
      readdata[STAT_BUSY]  = w_busy;
      readdata[CNT_W-1:0]  = w_cnt;
    end else begin
      readdata[DATA_W-1:0] = data_q;
    end
  end

  assign out_port = data_q;

endmodule

`default_nettype wire

// File: tb/tb_avalon_pio_pulse_out.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_pulse_out : directed bench with a deadline-based reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_avalon_pio_pulse_out;

  localparam int         DATA_W = 4;
  localparam logic [3:0] RV     = 4'hA;
  localparam int         P      = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        pulse_done;

  int n_cmp = 0;
  int n_err = 0;

  avalon_pio_pulse_out #(
    .DATA_W       (DATA_W),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (P)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_done (pulse_done)
  );

  always #5 clk = ~clk;

  // Reference model: a pulse is a deadline in absolute edge count
  int       m_cyc = 0;
  int       m_deadline = 0;
  logic     m_busy = 1'b0;
  logic [3:0] m_data = RV;
  logic [3:0] m_mask = 4'h0;
  logic     m_done = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RV; m_mask = 4'h0; m_busy = 1'b0; m_done = 1'b0; m_deadline = 0;
    end else begin
      logic [3:0] wd;
      logic       exp_now;
      m_cyc   = m_cyc + 1;
      wd      = writedata[3:0];
      exp_now = m_busy && (m_cyc == m_deadline);
      m_done  = 1'b0;
      if (exp_now) begin
        m_data = m_data & ~m_mask;
        m_mask = 4'h0;
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      if (chipselect && !write_n) begin
        if (address == 2'd0) m_data = wd;
        else if (address == 2'd1) m_data = m_data | wd;
        else if (address == 2'd2) m_data = m_data & ~wd;
        else if (wd != 4'h0) begin
          m_data     = m_data | wd;
          m_mask     = m_mask | wd;
          m_busy     = 1'b1;
          m_deadline = m_cyc + P;
          m_done     = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == 2'd3) begin
      r[31] = m_busy;
      if (m_busy) r[30:0] = 31'(m_deadline - m_cyc);
    end else begin
      r[3:0] = m_data;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_out_port", {28'h0, out_port}, {28'h0, m_data});
    chk("model_pulse_done", {31'h0, pulse_done}, {31'h0, m_done});
    chk("model_readdata", readdata, model_rd(address));
  end

  // Write takes effect on the edge following the negedge where it is driven
  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = {28'hABCDE00, d};
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'hFFFF_FFF0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int dn;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    address = 2'd3;
    @(negedge clk);
    chk("reset_out_port", {28'h0, out_port}, 32'hA);
    chk("reset_status", readdata, 32'h0);
    chk("reset_pulse_done", {31'h0, pulse_done}, 32'h0);

    wr(2'd0, 4'h5);
    chk("data_write", {28'h0, out_port}, 32'h5);
    wr(2'd1, 4'h2);
    chk("set_write", {28'h0, out_port}, 32'h7);
    wr(2'd2, 4'h4);
    chk("clr_write", {28'h0, out_port}, 32'h3);
    address = 2'd0;
    #1;
    chk("read_data", readdata, 32'h3);

    wr(2'd0, 4'h0);
    wr(2'd3, 4'h8);
    address = 2'd3;
    #1;
    chk("pulse_status_first", readdata, 32'h8000_0008);
    @(negedge clk);
    chk("pulse_status_dec", readdata, 32'h8000_0007);
    hi = 1; dn = 0;
    for (int k = 1; k < 12; k++) begin
      if (out_port[3]) hi++;
      if (pulse_done) dn++;
      @(negedge clk);
    end
    chk("pulse_width", 32'(hi), 32'd8);
    chk("pulse_done_count", 32'(dn), 32'd1);
    chk("pulse_busy_after", readdata, 32'h0);

    wr(2'd3, 4'h1);
    repeat (3) @(negedge clk);
    wr(2'd3, 4'h2);
    hi = 0; dn = 0;
    for (int k = 5; k < 17; k++) begin
      if (out_port[1:0] == 2'b11) hi++;
      if (pulse_done) dn++;
      @(negedge clk);
    end
    chk("retrig_both_high", 32'(hi), 32'd8);
    chk("retrig_done_count", 32'(dn), 32'd1);
    chk("retrig_out_after", {28'h0, out_port}, 32'h0);

    wr(2'd3, 4'h8);
    repeat (6) @(negedge clk);
    wr(2'd1, 4'h8);
    address = 2'd3;
    #1;
    chk("coinc_set_out", {28'h0, out_port}, 32'h8);
    chk("coinc_set_done", {31'h0, pulse_done}, 32'h1);
    chk("coinc_set_busy", readdata, 32'h0);
    wr(2'd0, 4'h0);

    wr(2'd3, 4'h8);
    repeat (6) @(negedge clk);
    wr(2'd3, 4'h4);
    address = 2'd3;
    #1;
    chk("coinc_pulse_done", {31'h0, pulse_done}, 32'h0);
    chk("coinc_pulse_status", readdata, 32'h8000_0008);
    chk("coinc_pulse_out", {28'h0, out_port}, 32'h4);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pulse_done) dn++;
    end
    chk("coinc_pulse_done_later", 32'(dn), 32'd1);
    chk("coinc_pulse_out_end", {28'h0, out_port}, 32'h0);

    wr(2'd3, 4'h2);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_out", {28'h0, out_port}, 32'hA);
    address = 2'd3;
    #1;
    chk("async_reset_status", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pulse_done) dn++;
    end
    chk("no_done_after_reset", 32'(dn), 32'd0);

    wr(2'd3, 4'h0);
    address = 2'd3;
    #1;
    chk("pulse_zero_out", {28'h0, out_port}, 32'hA);
    chk("pulse_zero_status", readdata, 32'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/avalon_pio_pulse_out.md
Name: avalon_pio_pulse_out

Overview:
- Parametrised Avalon-MM slave output port. It is the successor to the single-bit peripheral reset/control PIOs in the Platform Designer SoC, such as the USB and peripheral reset lines.
- Provides a DATA_W-bit output register with atomic set and clear, plus a hardware-timed auto-deasserting pulse, so software can issue fixed-width reset pulses without busy-wait timing.
- Sits on the Nios II data master bus and drives out_port to off-chip or peer-block reset/enable pins.

Parameters:
- DATA_W, 1, width of out_port and of the data register (1..32).
- RESET_VALUE, 0, value of out_port at reset (DATA_W bits).
- PULSE_CYCLES, 1000, width of the timed pulse in clk cycles (1..2^30).
- CNT_W, derived localparam, clog2(PULSE_CYCLES+1); not overridable.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, zero wait states
- out_port  out  DATA_W  driven output register
- pulse_done  out  1  one-cycle strobe when a timed pulse expires

Behaviour:
- Reset (asynchronous): data_out=RESET_VALUE, pulse_mask=0, cnt=0, busy=0, pulse_done=0.
- A write is chipselect && !write_n, sampled at the clk rising edge. Only writedata[DATA_W-1:0] is used; upper bits are ignored.
- Write effects, visible on out_port the cycle after the edge:
  - addr 0 DATA: data_out <= wd.
  - addr 1 SET: data_out |= wd.
  - addr 2 CLR: data_out &= ~wd.
  - addr 3 PULSE, wd != 0: data_out |= wd; pulse_mask <= pulse_mask | wd; cnt <= PULSE_CYCLES; busy <= 1.
  - addr 3 PULSE, wd == 0: no effect.
- Retrigger while busy: new mask bits are ORed into pulse_mask and cnt reloads to PULSE_CYCLES (the window extends).
- Timer, while busy: cnt decrements every cycle. Expiry is the cycle in which busy && cnt==1. On that edge:
  - data_out &= ~pulse_mask
  - pulse_mask <= 0
  - busy <= 0
  - pulse_done <= 1 for exactly one cycle
- Pulse width: a masked bit is high for exactly PULSE_CYCLES cycles, counted from the edge after the write.
- Expiry coincident with a CPU write, applied in order:
  1. Expiry clear.
  2. DATA/SET/CLR write applied on top, so the CPU write wins.
  3. A PULSE write on the expiry cycle counts as a retrigger: busy stays 1, cnt reloads, pulse_mask = new wd only, and pulse_done is not asserted.
- Bits set via DATA/SET during a pulse that are also in pulse_mask are still cleared at expiry. Bits cleared via CLR during a pulse stay cleared; the pulse keeps running and busy is unaffected.
- Reads are combinational and zero-latency; readdata depends on address alone, regardless of chipselect:
  - addr 0, 1, 2: zero-extended data_out.
  - addr 3: bit31=busy; bits[CNT_W-1:0]=cnt; all other bits 0.
- reset_n asserted mid-pulse aborts immediately to reset values; pulse_done is not generated.

Decomposition:
- Shared package pio_pkg:
  - Address constants ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_PULSE=3.
  - Status bit index STAT_BUSY=31.
  - clog2 function.
- One natural sub-module, pio_pulse_timer, containing cnt, busy, load/retrigger, and expiry/done generation.
- Top level keeps data_out, pulse_mask, the write decode and the read mux.

Test Plan:
- Reset with RESET_VALUE=4'hA, DATA_W=4 -> out_port=4'hA, readdata@3=0, pulse_done=0.
- Write DATA 4'h5, then SET 4'h2, then CLR 4'h4 -> out_port 5, then 7, then 3; readdata@0=32'h3.
- PULSE_CYCLES=8, write PULSE 4'h8 at edge E -> out_port[3]=1 for edges E..E+7 and 0 after E+8. readdata@3 reads 32'h8000_0008 the cycle after E and decrements each cycle. pulse_done is high one cycle; busy=0 after.
- Retrigger: PULSE 4'h1 at E, PULSE 4'h2 at E+5 -> bits 0 and 1 both fall at E+13; a single pulse_done.
- Coincident events: SET 4'h8 on the expiry cycle of a 4'h8 pulse -> bit 3 stays 1, pulse_done fires. Separately, PULSE on the expiry cycle -> no pulse_done, cnt reloads to 8.
- reset_n low at E+3 of a pulse -> out_port=RESET_VALUE asynchronously, busy=0, no pulse_done after release. Also: write PULSE 0 -> no change, busy stays 0.
